baud_gen_frac: RTL and testbench
================================

# baud_gen_frac

Fractional-divisor baud generator for the APB UART; the next generation of the integer 16x tick generator. It produces an oversample tick from a runtime divisor with integer and fractional parts, plus a bit-rate tick every programmable number of oversample ticks. A synchronous restart lets the receiver re-phase to a start-bit edge. Configuration comes from APB registers and is applied only at period boundaries, so bit timing never glitches.

## Interface
- DIV_WIDTH, 20, integer divisor width
- FRAC_WIDTH, 4, fractional divisor width (resolution 1/2^FRAC_WIDTH)
- OSR_WIDTH, 5, oversample-ratio field width
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous, active-low
- enable  in  1  generator enable (level)
- div_int  in  DIV_WIDTH  integer part of the divisor, in clk cycles per oversample tick
- div_frac  in  FRAC_WIDTH  fractional part of the divisor
- osr  in  OSR_WIDTH  oversample ratio minus 1; values below 3 are clamped to 3
- restart  in  1  synchronous re-phase pulse
- tick_os  out  1  one-cycle oversample tick
- tick_bit  out  1  one-cycle bit tick, coincident with the tick_os that ends each bit
- active  out  1  generator running

## Operation
- Effective divisor is div_int + div_frac/2^FRAC_WIDTH.
- Run condition is `run = enable && (div_int > 1)`, evaluated on the live inputs every cycle.
  - When run is 0: the cycle counter, oversample counter and accumulator are cleared, shadows load the live inputs, and active, tick_os and tick_bit are 0 from the next edge.
- Activation: on the first edge with run=1 while active=0, active is set to 1 and all counters start at 0.
- Shadow registers:
  - div_sh and frac_sh capture div_int and div_frac at every tick_os boundary.
  - osr_sh captures the clamped osr only at tick_bit boundaries.
  - All shadows also load at activation and on restart.
- Fractional accumulator: acc is FRAC_WIDTH bits and starts at 0. At each oversample period start, acc <= acc + frac_sh, modulo 2^FRAC_WIDTH. The carry out selects the period length:
  - carry 1: period = div_sh + 1
  - carry 0: period = div_sh
  - period is DIV_WIDTH+1 bits wide, so div_int at its maximum value does not overflow.
- Cycle counter: counts 0..period-1. At terminal count it wraps to 0 and tick_os is set to 1 for one cycle.
- Oversample counter os_cnt: counts 0..osr_sh. It advances on each oversample terminal count. When it is at osr_sh, it wraps and tick_bit is set in the same cycle as tick_os.
- restart (while run=1): clears the cycle counter, os_cnt and acc, and reloads the shadows. No tick is issued on that edge.
  - restart coincident with terminal count: restart wins and no tick is produced.
  - restart while run=0 is ignored.
- Precedence: reset > run=0 > restart > terminal count > count.

## Timing
- Reset values: active=0, tick_os=0, tick_bit=0; all counters, acc and shadows are 0.
- Outputs are registered; none are combinational from the inputs.
- First tick_os is high P edges after the edge that set active. P is the first period: div_int, or div_int+1 when the first accumulator add carries.
- After a restart, the next tick_os comes P edges after the restart edge. tick_bit comes after osr_sh+1 ticks.
- Changes to div_int or div_frac take effect with the period that follows the next tick_os. Changes to osr take effect after the next tick_bit.
- An invalid divisor or enable=0 stops the generator immediately: counters are cleared on the next edge, with no drain.
- Reset asserted mid-period clears everything asynchronously. Restart after reset release follows the activation rule.

## Structure
- uart_pkg holds the shared constants:
  - the default DIV_WIDTH, FRAC_WIDTH and OSR_WIDTH
  - OSR_MIN=3
  - the precedence encoding, if used
- One sub-module, baud_frac_acc, holds the FRAC_WIDTH accumulator plus carry and produces the period length for each oversample period. It has load/clear and step inputs.
- The top level holds the run/active logic, the shadows, the cycle counter and the oversample counter.

## Test plan
- Integer divisor: div_int=4, div_frac=0, osr=15, enable=1.
  - Expect active high after 1 edge, tick_os every 4 cycles, tick_bit every 64 cycles, coincident with every 16th tick_os.
- Fractional divisor: div_int=4, div_frac=8 (FRAC_WIDTH=4).
  - Expect periods alternating 4,5,4,5 and exactly 16 tick_os in 72 cycles.
  - Repeat with div_frac=1: one 5-cycle period per 16.
- Disable and clamp: div_int=1, or enable dropped mid-period.
  - Expect active=0 and both ticks 0 on the next edge.
  - Re-enabling restarts the counters from 0.
  - osr=1 behaves exactly like osr=3.
- Restart: with div_int=10, pulse restart on the terminal-count cycle.
  - Expect no tick on that edge, the next tick_os 10 cycles later, and os_cnt reset so tick_bit comes after osr+1 ticks.
- Live reconfiguration: change div_int from 8 to 3 mid-period.
  - Expect the current period to complete at 8 and subsequent periods to be 3.
  - Change osr mid-bit; the new ratio applies after the next tick_bit only.
- Reset mid-operation: assert rst_n low asynchronously between edges.
  - Expect all outputs to drop to 0 immediately.
  - After release, activation behaves as from power-up.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared constants for the UART baud generator.
//   DIV_WIDTH_DEF / FRAC_WIDTH_DEF / OSR_WIDTH_DEF : default field widths
//   OSR_MIN                                        : smallest legal oversample ratio minus 1
//   baud_ev_e                                      : per-cycle event, listed in precedence order
package uart_pkg;
  localparam int DIV_WIDTH_DEF  = 20;
  localparam int FRAC_WIDTH_DEF = 4;
  localparam int OSR_WIDTH_DEF  = 5;
  localparam int OSR_MIN        = 3;

  // Highest precedence first: stop > (re)start > terminal count > count.
  typedef enum logic [1:0] {
    EV_OFF   = 2'd0,
    EV_START = 2'd1,
    EV_TC    = 2'd2,
    EV_COUNT = 2'd3
  } baud_ev_e;
endpackage

// File: rtl/baud_gen_frac_if.sv
// Configuration/tick bundle of the fractional baud generator.
//   master : register block side (drives config and restart, observes ticks)
//   slave  : generator side
interface baud_gen_frac_if import uart_pkg::*; #(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int OSR_WIDTH  = OSR_WIDTH_DEF
) ();
  logic                  enable;
  logic [DIV_WIDTH-1:0]  div_int;
  logic [FRAC_WIDTH-1:0] div_frac;
  logic [OSR_WIDTH-1:0]  osr;
  logic                  restart;
  logic                  tick_os;
  logic                  tick_bit;
  logic                  active;

  modport master (output enable, div_int, div_frac, osr, restart,
                  input  tick_os, tick_bit, active);
  modport slave  (input  enable, div_int, div_frac, osr, restart,
                  output tick_os, tick_bit, active);
endinterface

// File: rtl/baud_frac_acc.sv
// Fractional phase accumulator for one oversample period.
//   clr_i    : restart the phase at 0 (inactive, activation, restart)
//   step_i   : advance by frac_i at the end of a period
//   div_i    : integer divisor of the current period
//   frac_i   : fractional divisor of the current period
//   period_o : length of the current period, div_i or div_i+1
// acc_q holds the phase before the current period's add; the carry of
// acc_q + frac_i stretches the current period by one cycle, and that sum
// becomes the phase of the next period.
module baud_frac_acc import uart_pkg::*; #(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr_i,
  input  logic                  step_i,
  input  logic [DIV_WIDTH-1:0]  div_i,
  input  logic [FRAC_WIDTH-1:0] frac_i,
  output logic [DIV_WIDTH:0]    period_o
);
  logic [FRAC_WIDTH-1:0] acc_q, acc_d;
  logic [FRAC_WIDTH:0]   sum;

  assign sum      = {1'b0, acc_q} + {1'b0, frac_i};
  assign period_o = {1'b0, div_i} + {{DIV_WIDTH{1'b0}}, sum[FRAC_WIDTH]};

  always_comb begin
    acc_d = acc_q;
    if (clr_i)       acc_d = '0;
    else if (step_i) acc_d = sum[FRAC_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/baud_gen_frac.sv
// Fractional-divisor baud generator.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : enable, div_int, div_frac, osr, restart in;
//                tick_os, tick_bit, active out (all registered)
// Divisors are sampled into shadows at every tick_os, osr at every
// tick_bit, so a running bit never changes length mid-period.
module baud_gen_frac import uart_pkg::*; #(
  parameter int DIV_WIDTH  = DIV_WIDTH_DEF,
  parameter int FRAC_WIDTH = FRAC_WIDTH_DEF,
  parameter int OSR_WIDTH  = OSR_WIDTH_DEF
) (
  input  logic           clk,
  input  logic           rst_n,
  baud_gen_frac_if.slave bus
);
  logic                  run, tc, bit_end;
  logic [OSR_WIDTH-1:0]  osr_clamped;
  logic [DIV_WIDTH:0]    period;
  baud_ev_e              ev;

  logic                  active_q, active_d;
  logic                  tick_os_q, tick_os_d;
  logic                  tick_bit_q, tick_bit_d;
  logic [DIV_WIDTH:0]    cnt_q, cnt_d;
  logic [OSR_WIDTH-1:0]  os_q, os_d;
  logic [DIV_WIDTH-1:0]  div_sh_q, div_sh_d;
  logic [FRAC_WIDTH-1:0] frac_sh_q, frac_sh_d;
  logic [OSR_WIDTH-1:0]  osr_sh_q, osr_sh_d;

  assign run         = bus.enable && (bus.div_int > DIV_WIDTH'(1));
  assign osr_clamped = (bus.osr < OSR_WIDTH'(OSR_MIN)) ? OSR_WIDTH'(OSR_MIN) : bus.osr;
  // period >= 2 whenever active, since div_sh only loads while run holds
  assign tc          = (cnt_q == period - {{DIV_WIDTH{1'b0}}, 1'b1});
  assign bit_end     = (os_q == osr_sh_q);

  always_comb begin
    if (!run)                      ev = EV_OFF;
    else if (!active_q || bus.restart) ev = EV_START;
    else if (tc)                   ev = EV_TC;
    else                           ev = EV_COUNT;
  end

  baud_frac_acc #(.DIV_WIDTH(DIV_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)) u_acc (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    ((ev == EV_OFF) || (ev == EV_START)),
    .step_i   (ev == EV_TC),
    .div_i    (div_sh_q),
    .frac_i   (frac_sh_q),
    .period_o (period)
  );

  always_comb begin
    active_d   = active_q;
    tick_os_d  = 1'b0;
    tick_bit_d = 1'b0;
    cnt_d      = cnt_q;
    os_d       = os_q;
    div_sh_d   = div_sh_q;
    frac_sh_d  = frac_sh_q;
    osr_sh_d   = osr_sh_q;
    case (ev)
      EV_OFF, EV_START: begin
        active_d  = (ev == EV_START);
        cnt_d     = '0;
        os_d      = '0;
        div_sh_d  = bus.div_int;
        frac_sh_d = bus.div_frac;
        osr_sh_d  = osr_clamped;
      end
      EV_TC: begin
        cnt_d     = '0;
        tick_os_d = 1'b1;
        div_sh_d  = bus.div_int;
        frac_sh_d = bus.div_frac;
        if (bit_end) begin
          os_d       = '0;
          tick_bit_d = 1'b1;
          osr_sh_d   = osr_clamped;
        end else begin
          os_d = os_q + OSR_WIDTH'(1);
        end
      end
      default: cnt_d = cnt_q + {{DIV_WIDTH{1'b0}}, 1'b1};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      tick_os_q  <= 1'b0;
      tick_bit_q <= 1'b0;
      cnt_q      <= '0;
      os_q       <= '0;
      div_sh_q   <= '0;
      frac_sh_q  <= '0;
      osr_sh_q   <= '0;
    end else begin
      active_q   <= active_d;
      tick_os_q  <= tick_os_d;
      tick_bit_q <= tick_bit_d;
      cnt_q      <= cnt_d;
      os_q       <= os_d;
      div_sh_q   <= div_sh_d;
      frac_sh_q  <= frac_sh_d;
      osr_sh_q   <= osr_sh_d;
    end
  end

  assign bus.active   = active_q;
  assign bus.tick_os  = tick_os_q;
  assign bus.tick_bit = tick_bit_q;
endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac. The reference model uses the
// closed form of the tick schedule: the k-th tick_os after (re)start
// lands k*div + floor(k*frac/16) edges later, and every (osr_eff+1)-th
// tick is also a bit tick.
module tb_baud_gen_frac;
  logic clk, rst_n;
  int   tests, fails;

  baud_gen_frac_if #(.DIV_WIDTH(20), .FRAC_WIDTH(4), .OSR_WIDTH(5)) bus ();

  baud_gen_frac #(.DIV_WIDTH(20), .FRAC_WIDTH(4), .OSR_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Enable from an inactive state; returns just after the activation edge.
  task automatic activate(input int dv, input int fr, input int os);
    bus.enable  = 1'b0;
    bus.restart = 1'b0;
    @(posedge clk); #1;
    bus.div_int  = 20'(dv);
    bus.div_frac = 4'(fr);
    bus.osr      = 5'(os);
    bus.enable   = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.active !== 1'b1 || bus.tick_os !== 1'b0) begin
      fails++;
      $display("FAIL activate: active=%0b tick_os=%0b, expected 1/0", bus.active, bus.tick_os);
    end
  endtask

  // Checks nedges edges after a (re)start edge against the closed-form schedule.
  task automatic check_trace(input int dv, input int fr, input int os, input int nedges,
                             input string nm, output int nticks);
    int   k, t_next, oeff, bad_n;
    logic exp_os, exp_bit, got_os, got_bit, got_act;
    oeff   = (os < 3) ? 3 : os;
    k      = 1;
    t_next = dv + fr / 16;
    bad_n  = -1;
    nticks = 0;
    got_os = 0; got_bit = 0; got_act = 0; exp_os = 0; exp_bit = 0;
    for (int n = 1; n <= nedges; n++) begin
      logic eo, eb;
      @(posedge clk); #1;
      eo = (n == t_next);
      eb = eo && ((k % (oeff + 1)) == 0);
      if (eo) begin
        k++;
        t_next = k * dv + (k * fr) / 16;
      end
      if (bus.tick_os === 1'b1) nticks++;
      if (bad_n < 0 && (bus.tick_os !== eo || bus.tick_bit !== eb || bus.active !== 1'b1)) begin
        bad_n = n; got_os = bus.tick_os; got_bit = bus.tick_bit; got_act = bus.active;
        exp_os = eo; exp_bit = eb;
      end
    end
    tests++;
    if (bad_n >= 0) begin
      fails++;
      $display("FAIL %s: edge %0d tick_os=%0b tick_bit=%0b active=%0b, expected %0b/%0b/1 (div=%0d frac=%0d osr=%0d)",
               nm, bad_n, got_os, got_bit, got_act, exp_os, exp_bit, dv, fr, os);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    bus.enable = 1'b1; bus.div_int = 20'd4; bus.div_frac = 4'd0;
    bus.osr = 5'd15; bus.restart = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++;
    if (bus.active !== 1'b0) begin fails++; $display("FAIL reset_active: got %0b, expected 0", bus.active); end
    tests++;
    if (bus.tick_os !== 1'b0) begin fails++; $display("FAIL reset_tick_os: got %0b, expected 0", bus.tick_os); end
    tests++;
    if (bus.tick_bit !== 1'b0) begin fails++; $display("FAIL reset_tick_bit: got %0b, expected 0", bus.tick_bit); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_integer;
    int nt;
    activate(4, 0, 15);
    check_trace(4, 0, 15, 140, "integer_div4", nt);
    tests++;
    if (nt != 140 / 4) begin fails++; $display("FAIL integer_count: got %0d ticks, expected %0d", nt, 140 / 4); end
  endtask

  task automatic test_fractional;
    int nt;
    activate(4, 8, 15);
    check_trace(4, 8, 15, 72, "frac_half", nt);
    tests++;
    if (nt != 16) begin fails++; $display("FAIL frac_half_count: got %0d ticks in 72 cycles, expected 16", nt); end
    activate(4, 1, 15);
    check_trace(4, 1, 15, 65, "frac_sixteenth", nt);
    tests++;
    if (nt != 16) begin fails++; $display("FAIL frac_sixteenth_count: got %0d ticks in 65 cycles, expected 16", nt); end
  endtask

  task automatic test_disable;
    int nt;
    activate(4, 0, 15);
    check_trace(4, 0, 15, 7, "pre_disable", nt);
    bus.enable = 1'b0;               // edge 8 would otherwise tick
    @(posedge clk); #1;
    tests++;
    if (bus.active !== 1'b0 || bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0) begin
      fails++;
      $display("FAIL disable_stop: active=%0b tick_os=%0b tick_bit=%0b, expected 0/0/0",
               bus.active, bus.tick_os, bus.tick_bit);
    end
    bus.div_int = 20'd1; bus.enable = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (bus.active !== 1'b0) begin fails++; $display("FAIL div1_inactive: active=%0b, expected 0", bus.active); end
    activate(5, 0, 1);
    check_trace(5, 0, 1, 45, "osr_clamp", nt);
    bus.div_int = 20'd1;
    @(posedge clk); #1;
    tests++;
    if (bus.active !== 1'b0 || bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0) begin
      fails++;
      $display("FAIL div1_stop: active=%0b tick_os=%0b tick_bit=%0b, expected 0/0/0",
               bus.active, bus.tick_os, bus.tick_bit);
    end
    activate(5, 0, 1);
    check_trace(5, 0, 3, 30, "reenable", nt);
  endtask

  task automatic test_restart;
    int nt;
    activate(10, 0, 3);
    check_trace(10, 0, 3, 29, "pre_restart", nt);
    bus.restart = 1'b1;              // edge 30 is a terminal count
    @(posedge clk); #1;
    bus.restart = 1'b0;
    tests++;
    if (bus.tick_os !== 1'b0 || bus.active !== 1'b1) begin
      fails++;
      $display("FAIL restart_no_tick: tick_os=%0b active=%0b, expected 0/1", bus.tick_os, bus.active);
    end
    check_trace(10, 0, 3, 45, "post_restart", nt);
  endtask

  task automatic test_reconfig;
    int   t_next, since, ratio, live_div, live_osr, first_tick, bad_n;
    logic eo, eb;
    activate(8, 0, 3);
    t_next = 8; since = 0; ratio = 4; live_div = 8; live_osr = 3;
    first_tick = -1; bad_n = -1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      eo = (n == t_next);
      eb = 1'b0;
      if (eo) begin
        since++;
        if (since == ratio) begin eb = 1'b1; since = 0; ratio = live_osr + 1; end
        t_next = n + live_div;
      end
      if (first_tick < 0 && bus.tick_os === 1'b1) first_tick = n;
      if (bad_n < 0 && (bus.tick_os !== eo || bus.tick_bit !== eb)) begin
        bad_n = n;
        $display("FAIL reconfig_trace: edge %0d tick_os=%0b tick_bit=%0b, expected %0b/%0b",
                 n, bus.tick_os, bus.tick_bit, eo, eb);
      end
      if (n == 3)  begin bus.div_int = 20'd3; live_div = 3; end
      if (n == 20) begin bus.osr = 5'd7; live_osr = 7; end
    end
    tests++;
    if (bad_n >= 0) fails++;
    tests++;
    if (first_tick != 8) begin fails++; $display("FAIL reconfig_first: first tick at edge %0d, expected 8", first_tick); end
  endtask

  task automatic test_reset_mid;
    int nt;
    activate(6, 0, 3);
    repeat (6) @(posedge clk);
    #2;
    tests++;
    if (bus.tick_os !== 1'b1) begin fails++; $display("FAIL pre_reset_tick: tick_os=%0b, expected 1", bus.tick_os); end
    rst_n = 1'b0;
    #1;
    tests++;
    if (bus.active !== 1'b0 || bus.tick_os !== 1'b0 || bus.tick_bit !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: active=%0b tick_os=%0b tick_bit=%0b, expected 0/0/0",
               bus.active, bus.tick_os, bus.tick_bit);
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    activate(6, 0, 3);
    check_trace(6, 0, 3, 30, "post_reset", nt);
  endtask

  task automatic test_random;
    int dv, fr, os, nt;
    for (int i = 0; i < 6; i++) begin
      dv = $urandom_range(2, 12);
      fr = $urandom_range(0, 15);
      os = $urandom_range(0, 7);
      activate(dv, fr, os);
      check_trace(dv, fr, os, 150, "random", nt);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_integer();
    test_fractional();
    test_disable();
    test_restart();
    test_reconfig();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
